// File: rtl/lpe_column_collector.sv
// Collects one packet of per-PE results from the bottom of a PE column, reorders
// them by PE index and streams them out as a single AXI-Stream packet.
module lpe_column_collector #(
    parameter int PE_NUMBER_J    = 4,
    parameter int U_D_WIDTH      = 16,
    parameter int RSLT_WIDTH     = 16,
    parameter int USER_WIDTH     = 8,
    parameter int OP1_USER_MASK  = 1 << (USER_WIDTH - 2),
    parameter int RSLT_USER_MASK = 1 << (USER_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [U_D_WIDTH-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [RSLT_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  err_user_flag,
    output logic                  err_index,
    output logic                  err_duplicate,
    output logic                  err_missing
);

    localparam int IDX_W = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1;
    localparam logic [IDX_W:0]          NUM_EXT   = (IDX_W + 1)'(PE_NUMBER_J);
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(PE_NUMBER_J - 1);
    localparam logic [USER_WIDTH-1:0]   RSLT_MASK = USER_WIDTH'(RSLT_USER_MASK);
    localparam logic [USER_WIDTH-1:0]   OP1_MASK  = USER_WIDTH'(OP1_USER_MASK);

    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [PE_NUMBER_J-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [RSLT_WIDTH-1:0]   buf_q [PE_NUMBER_J];
    logic                    wr_en;
    logic                    err_user_d, err_index_d, err_dup_d, err_miss_d;

    logic             beat_acc;
    logic             is_rslt;
    logic             is_op1;
    logic [IDX_W-1:0] idx;
    logic             idx_ok;
    logic             rd_last;

    assign beat_acc = s_axis_tvalid & s_axis_tready;
    assign is_rslt  = |(s_axis_tuser & RSLT_MASK);
    assign is_op1   = |(s_axis_tuser & OP1_MASK);
    assign idx      = s_axis_tuser[IDX_W-1:0];
    assign idx_ok   = ({1'b0, idx} < NUM_EXT);
    assign rd_last  = (rd_ptr_q == LAST_IDX);

    // Ready is gated by rst_n so the upstream sees 0 for the whole reset window.
    assign s_axis_tready = rst_n & (state_q == COLLECT);
    assign m_axis_tvalid = (state_q == DRAIN);
    assign m_axis_tlast  = m_axis_tvalid & rd_last;
    assign m_axis_tdata  = (m_axis_tvalid & valid_q[rd_ptr_q]) ? buf_q[rd_ptr_q] : '0;
    assign busy          = (state_q == DRAIN);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        err_user_d  = 1'b0;
        err_index_d = 1'b0;
        err_dup_d   = 1'b0;
        err_miss_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (beat_acc) begin
                    if (is_rslt) begin
                        if (!idx_ok) begin
                            err_index_d = 1'b1;
                        end else if (valid_q[idx]) begin
                            err_dup_d = 1'b1;
                        end else begin
                            wr_en        = 1'b1;
                            valid_d[idx] = 1'b1;
                        end
                        // Missing check sees this beat's own store.
                        if (s_axis_tlast) begin
                            state_d = DRAIN;
                            if (!(&valid_d)) err_miss_d = 1'b1;
                            if (idx != LAST_IDX) err_index_d = 1'b1;
                        end
                    end else if (!is_op1) begin
                        err_user_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (m_axis_tready) begin
                    if (rd_last) begin
                        valid_d  = '0;
                        rd_ptr_d = '0;
                        state_d  = COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            valid_q       <= '0;
            rd_ptr_q      <= '0;
            err_user_flag <= 1'b0;
            err_index     <= 1'b0;
            err_duplicate <= 1'b0;
            err_missing   <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            rd_ptr_q      <= rd_ptr_d;
            err_user_flag <= err_user_d;
            err_index     <= err_index_d;
            err_duplicate <= err_dup_d;
            err_missing   <= err_miss_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[idx] <= s_axis_tdata[RSLT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_lpe_column_collector.sv
// Randomised self-checking bench for lpe_column_collector (J=4, 16-bit results, 8-bit tuser).
module tb_lpe_column_collector;

    localparam int J  = 4;
    localparam int RW = 16;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  user;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [7:0]    s_axis_tuser;
    logic [RW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          err_user_flag, err_index, err_duplicate, err_missing;

    lpe_column_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err_user_flag (err_user_flag),
        .err_index     (err_index),
        .err_duplicate (err_duplicate),
        .err_missing   (err_missing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cnt_user = 0, cnt_idx = 0, cnt_dup = 0, cnt_miss = 0;
    int m_user, m_idx, m_dup, m_miss;
    logic [RW:0] exp_q[$];
    logic [RW:0] got_q[$];
    logic        hold_v = 1'b0;
    logic [RW:0] hold_val;

    // Per-cycle observation at the falling edge: error pulses, output stability, output capture.
    task automatic sample();
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (err_user_flag) cnt_user++;
            if (err_index) cnt_idx++;
            if (err_duplicate) cnt_dup++;
            if (err_missing) cnt_miss++;
            if (hold_v) begin
                total++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== hold_val) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b {last,data}=%h need v=1 %h",
                             m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, hold_val);
                end
            end
            total++;
            if (busy !== m_axis_tvalid || (busy && s_axis_tready !== 1'b0)) begin
                bad++;
                $display("FAIL busy_ready: got busy=%b mvalid=%b sready=%b need busy=mvalid, sready=0 when busy",
                         busy, m_axis_tvalid, s_axis_tready);
            end
            hold_v   = m_axis_tvalid && !m_axis_tready;
            hold_val = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t rb(input int idx, input logic [15:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.user = 8'h80 | 8'(idx);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t mk(input logic [7:0] user, input logic [15:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.user = user;
        b.last = last;
        return b;
    endfunction

    // Reference: first arrival per index wins, absent indices read as zero, output in index order.
    function automatic void model(input beat_t pkt[$]);
        logic [RW-1:0] ent [J];
        bit            seen [J];
        int            idx;
        bit            bad_idx;
        bit            missing;
        m_user = 0; m_idx = 0; m_dup = 0; m_miss = 0;
        for (int i = 0; i < J; i++) begin
            ent[i]  = '0;
            seen[i] = 0;
        end
        foreach (pkt[k]) begin
            if (pkt[k].user[7]) begin
                idx     = int'(pkt[k].user[1:0]);
                bad_idx = (idx >= J);
                if (!bad_idx) begin
                    if (seen[idx]) m_dup++;
                    else begin
                        ent[idx]  = pkt[k].data;
                        seen[idx] = 1;
                    end
                end
                if (pkt[k].last) begin
                    if (idx != J - 1) bad_idx = 1;
                    missing = 0;
                    for (int i = 0; i < J; i++) if (!seen[i]) missing = 1;
                    if (missing) m_miss++;
                end
                if (bad_idx) m_idx++;
            end else if (!pkt[k].user[6]) begin
                m_user++;
            end
        end
        for (int i = 0; i < J; i++) begin
            logic l;
            l = (i == J - 1);
            exp_q.push_back({l, ent[i]});
        end
    endfunction

    task automatic send_beat(input beat_t b);
        int w = 0;
        while (s_axis_tready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: got sready=%b need 1 within 50 cycles", s_axis_tready);
        end
        s_axis_tdata  = b.data;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
    endtask

    // mode 0: sink always ready; 1: random sink ready and input gaps; 2: 3-cycle stall after first output
    task automatic run_packet(input string name, input beat_t pkt[$], input int mode);
        int u0, i0, d0, s0, cyc;
        exp_q.delete();
        got_q.delete();
        model(pkt);
        u0 = cnt_user; i0 = cnt_idx; d0 = cnt_dup; s0 = cnt_miss;
        m_axis_tready = 1'b1;
        foreach (pkt[k]) begin
            if (mode == 1 && k > 0 && $urandom_range(0, 3) == 0) tick();
            send_beat(pkt[k]);
        end
        total++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: got mvalid=%b busy=%b need 1 1", name, m_axis_tvalid, busy);
        end
        if (mode == 2) begin
            tick();
            m_axis_tready = 1'b0;
            repeat (3) begin
                tick();
                total++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== exp_q[1] ||
                    s_axis_tready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s stall: got v=%b {last,data}=%h sready=%b need v=1 %h sready=0",
                             name, m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, s_axis_tready, exp_q[1]);
                end
            end
            m_axis_tready = 1'b1;
        end
        cyc = 0;
        while (got_q.size() < J && cyc < 200) begin
            if (mode == 1) m_axis_tready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        m_axis_tready = 1'b1;
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout: got %0d beats need %0d", name, got_q.size(), J);
        end
        if (mode == 0) begin
            total++;
            if (cyc != J) begin
                bad++;
                $display("FAIL %s consecutive: got %0d cycles need %0d", name, cyc, J);
            end
        end
        total++;
        if (got_q.size() != J) begin
            bad++;
            $display("FAIL %s beat_count: got %0d need %0d", name, got_q.size(), J);
        end
        for (int i = 0; i < J && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s beat%0d: got {last,data}=%h need %h", name, i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL %s back_to_collect: got busy=%b sready=%b need 0 1", name, busy, s_axis_tready);
        end
        total++;
        if (cnt_user - u0 != m_user || cnt_idx - i0 != m_idx ||
            cnt_dup - d0 != m_dup || cnt_miss - s0 != m_miss) begin
            bad++;
            $display("FAIL %s errors: got user=%0d idx=%0d dup=%0d miss=%0d need %0d %0d %0d %0d", name,
                     cnt_user - u0, cnt_idx - i0, cnt_dup - d0, cnt_miss - s0, m_user, m_idx, m_dup, m_miss);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, err_user_flag, err_index,
             err_duplicate, err_missing} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got sready,mvalid,mlast,busy,errs=%b need 00000000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, err_user_flag, err_index,
                      err_duplicate, err_missing});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got sready=%b mvalid=%b need 1 0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_ordered();
        beat_t pkt[$];
        for (int i = 0; i < J; i++) pkt.push_back(rb(i, 16'(8'h11 * (i + 1)), i == J - 1));
        run_packet("ordered", pkt, 0);
    endtask

    task automatic test_out_of_order();
        beat_t pkt[$];
        pkt.push_back(rb(2, 16'hC, 0));
        pkt.push_back(rb(0, 16'hA, 0));
        pkt.push_back(rb(1, 16'hB, 0));
        pkt.push_back(rb(3, 16'hD, 1));
        run_packet("out_of_order", pkt, 0);
    endtask

    task automatic test_weights();
        beat_t pkt[$];
        pkt.push_back(mk(8'h40, 16'hBEEF, 0));
        pkt.push_back(rb(0, 16'h11, 0));
        pkt.push_back(mk(8'h40, 16'hCAFE, 1));
        pkt.push_back(rb(1, 16'h22, 0));
        pkt.push_back(rb(2, 16'h33, 0));
        pkt.push_back(mk(8'h40, 16'h0F0F, 0));
        pkt.push_back(rb(3, 16'h44, 1));
        run_packet("weights", pkt, 0);
    endtask

    task automatic test_dup_missing();
        beat_t pkt[$];
        pkt.push_back(rb(0, 16'h5, 0));
        pkt.push_back(rb(0, 16'h6, 0));
        pkt.push_back(rb(2, 16'h77, 0));
        pkt.push_back(rb(3, 16'h88, 1));
        run_packet("dup_missing", pkt, 0);
    endtask

    task automatic test_stall_user();
        beat_t pkt[$];
        pkt.push_back(mk(8'h00, 16'hDEAD, 0));
        for (int i = 0; i < J; i++) pkt.push_back(rb(i, 16'h101 + 16'(i), i == J - 1));
        run_packet("stall_user", pkt, 2);
    endtask

    task automatic test_reset_mid_drain();
        beat_t pkt[$];
        int    w = 0;
        for (int i = 0; i < J; i++) send_beat(rb(i, 16'h9000 + 16'(i), i == J - 1));
        got_q.delete();
        while (got_q.size() < 2 && w < 20) begin
            tick();
            w++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0 || w >= 20) begin
            bad++;
            $display("FAIL reset_mid_drain: got mvalid=%b busy=%b mlast=%b waited=%0d need 0 0 0 <20",
                     m_axis_tvalid, busy, m_axis_tlast, w);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_release: got sready=%b need 1", s_axis_tready);
        end
        got_q.delete();
        repeat (6) tick();
        total++;
        if (got_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_abandon: got %0d stale beats mvalid=%b need 0 0", got_q.size(), m_axis_tvalid);
        end
        for (int i = 0; i < J; i++) pkt.push_back(rb(3 - i, 16'($urandom_range(0, 65535)), i == J - 1 ? 1'b0 : 1'b0));
        pkt.push_back(rb(3, 16'h7E57, 1));
        run_packet("after_reset", pkt, 1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            beat_t pkt[$];
            int    n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 5))
                    0: pkt.push_back(mk(8'h40 | 8'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)),
                                        1'($urandom_range(0, 1))));
                    1: pkt.push_back(mk(8'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)),
                                        1'($urandom_range(0, 1))));
                    default: pkt.push_back(mk(8'h80 | 8'($urandom_range(0, 127)),
                                              16'($urandom_range(0, 65535)), 1'b0));
                endcase
            end
            if ($urandom_range(0, 3) == 0)
                pkt.push_back(mk(8'h80 | 8'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)), 1'b1));
            else
                pkt.push_back(mk(8'h80 | (8'($urandom_range(0, 31)) << 2) | 8'h03,
                                 16'($urandom_range(0, 65535)), 1'b1));
            run_packet("random", pkt, 1);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_ordered();
        test_out_of_order();
        test_weights();
        test_dup_missing();
        test_stall_user();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion need finish before 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/lpe_column_collector.md
LPE_COLUMN_COLLECTOR -- requirements
Module: lpe_column_collector

Interface
REQ-001 SHALL have parameter PE_NUMBER_J, default 4: number of PEs in the column and number of results per output packet.
REQ-002 SHALL have parameter U_D_WIDTH, default 16: width of the incoming down-stream tdata.
REQ-003 SHALL have parameter RSLT_WIDTH, default 16, where RSLT_WIDTH <= U_D_WIDTH: width of the output result tdata.
REQ-004 SHALL have parameter USER_WIDTH, default 8: width of the incoming tuser.
REQ-005 SHALL have parameter OP1_USER_MASK, default 1<<(USER_WIDTH-2): tuser flag that marks a forwarded-weight beat.
REQ-006 SHALL have parameter RSLT_USER_MASK, default 1<<(USER_WIDTH-1): tuser flag that marks a result beat.
REQ-007 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_axis_tdata  in  U_D_WIDTH  down stream from the bottom PE of the column.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- s_axis_tuser  in  USER_WIDTH
- m_axis_tdata  out  RSLT_WIDTH  ordered column results.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- busy  out  1  high while in DRAIN.
- err_user_flag, err_index, err_duplicate, err_missing  out  1 each  single-cycle error pulses.

Function
REQ-008 SHALL implement two states: COLLECT and DRAIN.
REQ-009 In COLLECT, SHALL drive s_axis_tready=1; in DRAIN, SHALL drive s_axis_tready=0.
REQ-010 Beat acceptance SHALL be s_axis_tvalid & s_axis_tready.
REQ-011 SHALL classify each accepted beat as follows:
- (tuser & RSLT_USER_MASK) != 0 -> result beat.
- otherwise (tuser & OP1_USER_MASK) != 0 -> weight beat: discarded, its tlast ignored.
- otherwise -> discarded, err_user_flag pulsed on the next cycle.
REQ-012 Result index SHALL be tuser[IDX_W-1:0], where IDX_W = max(1, clog2(PE_NUMBER_J)).
REQ-013 A result with index >= PE_NUMBER_J SHALL be dropped and SHALL pulse err_index.
REQ-014 A valid result SHALL be stored as tdata[RSLT_WIDTH-1:0] in buffer entry [index] and SHALL set valid bit [index].
REQ-015 A result whose entry is already valid SHALL be dropped (the first value is kept) and SHALL pulse err_duplicate.
REQ-016 An accepted result beat with tlast=1 SHALL move the state to DRAIN on the same clock edge, after its own store or drop.
- If any valid bit is still clear at that point, SHALL pulse err_missing.
- If that beat's index != PE_NUMBER_J-1, SHALL also pulse err_index; the data is still stored when the index is in range.
REQ-017 In DRAIN, SHALL drive m_axis_tvalid=1, m_axis_tdata = entry[rd_ptr] (0 if not valid), and m_axis_tlast = (rd_ptr == PE_NUMBER_J-1).
REQ-018 Output latency: the first output beat SHALL be valid in the cycle immediately after the tlast beat is accepted.
REQ-019 Output order SHALL be index 0 .. PE_NUMBER_J-1, independent of arrival order.
REQ-020 rd_ptr SHALL advance only on m_axis_tvalid & m_axis_tready.
REQ-021 While m_axis_tready=0, tdata, tlast and tvalid SHALL stay stable.
REQ-022 On the handshake of the tlast output beat, SHALL clear all valid bits, set rd_ptr=0 and return to COLLECT; s_axis_tready SHALL be 1 on the next cycle.
REQ-023 In COLLECT, SHALL drive m_axis_tvalid=0.
REQ-024 busy SHALL equal (state == DRAIN).
REQ-025 Error pulses SHALL be registered, last exactly one cycle per offending beat, and never block the datapath.
REQ-026 For PE_NUMBER_J=1, a single result beat with tlast SHALL produce one output beat with tlast=1.

Reset
REQ-027 While rst_n=0, SHALL immediately force:
- state = COLLECT, rd_ptr = 0, all valid bits = 0;
- m_axis_tvalid = 0, m_axis_tlast = 0, busy = 0, all error outputs = 0.
REQ-028 Buffer data contents need not be reset.
REQ-029 Reset asserted mid-DRAIN SHALL abandon the packet; no beat of it SHALL appear after rst_n rises.
REQ-030 s_axis_tready SHALL be 0 during reset and 1 in the first cycle after rst_n=1.

Verification
(J=4, RSLT_WIDTH=16, USER_WIDTH=8, RSLT_USER_MASK=0x80, OP1_USER_MASK=0x40)
REQ-031 Results idx 0,1,2,3, tdata 0x11,0x22,0x33,0x44, tlast on idx3, m_tready=1 -> out 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting the cycle after tlast; tlast only on 0x44; busy high for those 4 cycles.
REQ-032 Arrival order idx 2,0,1,3 with data 0xC,0xA,0xB,0xD -> out 0xA,0xB,0xC,0xD; no error pulses.
REQ-033 Weight beats (tuser 0x40, one with tlast) interleaved with results -> no output from weights; s_tready stays 1; result packet as in REQ-031.
REQ-034 idx1 never sent, idx0 sent twice (0x5, 0x6), tlast on idx3 -> err_duplicate x1, err_missing x1; out 0x5,0x0,<idx2>,<idx3>.
REQ-035 m_tready=0 for 3 cycles mid-drain -> beat held stable; s_tready=0 throughout; tuser 0x00 beat sent during COLLECT -> err_user_flag pulse, beat dropped.
REQ-036 rst_n low after 2nd output beat -> m_tvalid=0 immediately; after release, s_tready=1 and a fresh 4-result packet drains correctly.
